// File: rtl/gpu_scanout_pkg.sv
// ============================================================================
// gpu_scanout_pkg : shared types and helpers for the VGA scanout engine
// Rev 1.0
// ============================================================================
`default_nettype none

package gpu_scanout_pkg;

  localparam int unsigned WORD_BITS = 32;

  // One pixel's worth of pipeline side-band carried alongside the BRAM read
  typedef struct packed {
    logic       vis;
    logic       hs;
    logic       vs;
    logic [1:0] lane;
  } pipe_t;

  function automatic int unsigned bytes_shift(input int unsigned pixel_bits);
    if (pixel_bits == 32) return 2;
    if (pixel_bits == 16) return 1;
    return 0;
  endfunction

  // Widen a CB-bit channel (right-aligned in c) to 4 bits by repeating its MSBs
  function automatic logic [3:0] expand_chan(input logic [3:0] c, input int unsigned cb);
    logic [3:0] r;
    r = c;
    case (cb)
      1:       r = {4{c[0]}};
      2:       r = {c[1:0], c[1:0]};
      3:       r = {c[2:0], c[2]};
      default: r = c;
    endcase
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpu_scanout_timing.sv
// ============================================================================
// gpu_scanout_timing : VGA h/v counters with visible/sync/vblank/frame decode
// Rev 1.0
// ============================================================================
`default_nettype none

module gpu_scanout_timing #(
  parameter int unsigned H_VIS_AREA_PXL    = 800,
  parameter int unsigned H_FRONT_PORCH_PXL = 40,
  parameter int unsigned H_SYNC_PULSE_PXL  = 128,
  parameter int unsigned H_BACK_PORCH_PXL  = 88,
  parameter int unsigned V_VIS_AREA_PXL    = 600,
  parameter int unsigned V_FRONT_PORCH_PXL = 1,
  parameter int unsigned V_SYNC_PULSE_PXL  = 4,
  parameter int unsigned V_BACK_PORCH_PXL  = 23,
  parameter int unsigned H_NUM_BITS        = 11,
  parameter int unsigned V_NUM_BITS        = 10
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  output logic [H_NUM_BITS-1:0] h_o,
  output logic [V_NUM_BITS-1:0] v_o,
  output logic                  visible_o,
  output logic                  hsync_o,
  output logic                  vsync_o,
  output logic                  vblank_o,
  output logic                  frame_o
);

  localparam int unsigned H_TOTAL = H_VIS_AREA_PXL + H_FRONT_PORCH_PXL + H_SYNC_PULSE_PXL + H_BACK_PORCH_PXL;
  localparam int unsigned V_TOTAL = V_VIS_AREA_PXL + V_FRONT_PORCH_PXL + V_SYNC_PULSE_PXL + V_BACK_PORCH_PXL;
  localparam int unsigned H_SYNC_START = H_VIS_AREA_PXL + H_FRONT_PORCH_PXL;
  localparam int unsigned V_SYNC_START = V_VIS_AREA_PXL + V_FRONT_PORCH_PXL;

  logic [H_NUM_BITS-1:0] h_q, h_d;
  logic [V_NUM_BITS-1:0] v_q, v_d;

  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (h_q == H_NUM_BITS'(H_TOTAL - 1)) begin
      h_d = '0;
      v_d = (v_q == V_NUM_BITS'(V_TOTAL - 1)) ? '0 : v_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  assign h_o       = h_q;
  assign v_o       = v_q;
  assign visible_o = (h_q < H_NUM_BITS'(H_VIS_AREA_PXL)) && (v_q < V_NUM_BITS'(V_VIS_AREA_PXL));
  assign hsync_o   = (h_q >= H_NUM_BITS'(H_SYNC_START)) &&
                     (h_q <  H_NUM_BITS'(H_SYNC_START + H_SYNC_PULSE_PXL));
  assign vsync_o   = (v_q >= V_NUM_BITS'(V_SYNC_START)) &&
                     (v_q <  V_NUM_BITS'(V_SYNC_START + V_SYNC_PULSE_PXL));
  assign vblank_o  = (v_q >= V_NUM_BITS'(V_VIS_AREA_PXL));
  assign frame_o   = (h_q == '0) && (v_q == '0);

endmodule

`default_nettype wire

// File: rtl/gpu_scanout.sv
// ============================================================================
// gpu_scanout : VGA scanout engine - timing, frame-buffer fetch, page flip
// Rev 1.0
// ============================================================================
`default_nettype none

module gpu_scanout
  import gpu_scanout_pkg::*;
#(
  parameter int unsigned H_VIS_AREA_PXL    = 800,
  parameter int unsigned H_FRONT_PORCH_PXL = 40,
  parameter int unsigned H_SYNC_PULSE_PXL  = 128,
  parameter int unsigned H_BACK_PORCH_PXL  = 88,
  parameter int unsigned V_VIS_AREA_PXL    = 600,
  parameter int unsigned V_FRONT_PORCH_PXL = 1,
  parameter int unsigned V_SYNC_PULSE_PXL  = 4,
  parameter int unsigned V_BACK_PORCH_PXL  = 23,
  parameter int unsigned H_NUM_BITS        = 11,
  parameter int unsigned V_NUM_BITS        = 10,
  parameter int unsigned SCALE_SHIFT       = 1,
  parameter int unsigned PIXEL_BITS        = 8,
  parameter int unsigned CHANNEL_BITS      = 2,
  parameter int unsigned READ_LATENCY      = 1,
  parameter bit          HS_POL            = 1'b1,
  parameter bit          VS_POL            = 1'b1,
  parameter logic [31:0] FB_BASE_RESET     = 32'h0
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [31:0] fb_base_next,
  input  logic        flip_req,
  output logic        flip_ack,
  output logic        frame_start,
  output logic        vblank,
  output logic [31:0] buffer_addr,
  output logic        buffer_en,
  input  logic [31:0] buffer_dout,
  output logic [3:0]  VGA_R,
  output logic [3:0]  VGA_G,
  output logic [3:0]  VGA_B,
  output logic        VGA_HS,
  output logic        VGA_VS
);

  localparam int unsigned BPP_SHIFT = bytes_shift(PIXEL_BITS);
  localparam int unsigned ROW_PIX   = H_VIS_AREA_PXL >> SCALE_SHIFT;
  localparam int unsigned C         = CHANNEL_BITS;

  logic [H_NUM_BITS-1:0] w_h;
  logic [V_NUM_BITS-1:0] w_v;
  logic w_vis, w_hs, w_vs, w_vblank, w_frame;

  gpu_scanout_timing #(
    .H_VIS_AREA_PXL   (H_VIS_AREA_PXL),
    .H_FRONT_PORCH_PXL(H_FRONT_PORCH_PXL),
    .H_SYNC_PULSE_PXL (H_SYNC_PULSE_PXL),
    .H_BACK_PORCH_PXL (H_BACK_PORCH_PXL),
    .V_VIS_AREA_PXL   (V_VIS_AREA_PXL),
    .V_FRONT_PORCH_PXL(V_FRONT_PORCH_PXL),
    .V_SYNC_PULSE_PXL (V_SYNC_PULSE_PXL),
    .V_BACK_PORCH_PXL (V_BACK_PORCH_PXL),
    .H_NUM_BITS       (H_NUM_BITS),
    .V_NUM_BITS       (V_NUM_BITS)
  ) u_timing (
    .clk_i    (vga_clk),
    .rst_i    (reset),
    .h_o      (w_h),
    .v_o      (w_v),
    .visible_o(w_vis),
    .hsync_o  (w_hs),
    .vsync_o  (w_vs),
    .vblank_o (w_vblank),
    .frame_o  (w_frame)
  );

  logic [31:0] fb_base_q;
  logic [31:0] w_pix_idx, w_byte;
  logic        w_flip;
  pipe_t       w_stage_a;

  always_comb begin
    w_pix_idx = (32'(w_v) >> SCALE_SHIFT) * 32'(ROW_PIX) + (32'(w_h) >> SCALE_SHIFT);
    w_byte    = fb_base_q + (w_pix_idx << BPP_SHIFT);
    w_stage_a.vis  = w_vis;
    w_stage_a.hs   = w_hs;
    w_stage_a.vs   = w_vs;
    w_stage_a.lane = w_byte[1:0] >> BPP_SHIFT;
  end

  // Base only moves on the first vblank line so a frame never mixes pages
  assign w_flip = flip_req && (w_h == '0) && (w_v == V_NUM_BITS'(V_VIS_AREA_PXL));

  logic [31:0] addr_q;
  logic        en_q, ack_q, frame_q, vblank_q;
  pipe_t       stage_a_q;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      fb_base_q <= FB_BASE_RESET;
      addr_q    <= '0;
      en_q      <= 1'b0;
      ack_q     <= 1'b0;
      frame_q   <= 1'b0;
      vblank_q  <= 1'b0;
      stage_a_q <= '0;
    end else begin
      if (w_flip) fb_base_q <= fb_base_next & 32'hFFFF_FFFC;
      addr_q    <= w_byte & 32'hFFFF_FFFC;
      en_q      <= w_vis;
      ack_q     <= w_flip;
      frame_q   <= w_frame;
      vblank_q  <= w_vblank;
      stage_a_q <= w_stage_a;
    end
  end

  pipe_t w_late;

  generate
    if (READ_LATENCY == 0) begin : g_no_delay
      assign w_late = stage_a_q;
    end else begin : g_delay
      pipe_t dl_q [READ_LATENCY];
      always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
          for (int i = 0; i < READ_LATENCY; i++) dl_q[i] <= '0;
        end else begin
          dl_q[0] <= stage_a_q;
          for (int i = 1; i < READ_LATENCY; i++) dl_q[i] <= dl_q[i-1];
        end
      end
      assign w_late = dl_q[READ_LATENCY-1];
    end
  endgenerate

  logic [4:0]       w_shamt;
  logic [3*C-1:0]   w_rgb;
  logic [3:0]       r_q, g_q, b_q;
  logic             hs_q, vs_q;

  always_comb begin
    w_shamt = 5'(w_late.lane) * 5'(PIXEL_BITS);
    w_rgb   = (3*C)'(buffer_dout >> w_shamt);
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      r_q  <= '0;
      g_q  <= '0;
      b_q  <= '0;
      hs_q <= ~HS_POL;
      vs_q <= ~VS_POL;
    end else begin
      r_q  <= w_late.vis ? expand_chan(4'(w_rgb[3*C-1 -: C]), C) : 4'h0;
      g_q  <= w_late.vis ? expand_chan(4'(w_rgb[2*C-1 -: C]), C) : 4'h0;
      b_q  <= w_late.vis ? expand_chan(4'(w_rgb[C-1 -: C]), C)   : 4'h0;
      hs_q <= w_late.hs ? HS_POL : ~HS_POL;
      vs_q <= w_late.vs ? VS_POL : ~VS_POL;
    end
  end

  assign buffer_addr = addr_q;
  assign buffer_en   = en_q;
  assign flip_ack    = ack_q;
  assign frame_start = frame_q;
  assign vblank      = vblank_q;
  assign VGA_R       = r_q;
  assign VGA_G       = g_q;
  assign VGA_B       = b_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;

endmodule

`default_nettype wire

// File: tb/tb_gpu_scanout.sv
// ============================================================================
// tb_gpu_scanout : directed bench for gpu_scanout on a tiny 14x7 raster
// Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_gpu_scanout;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [31:0] fb_base_next = 32'h0;
  logic        flip_req = 1'b0;
  logic        ovr = 1'b0;

  logic        ack8, fs8, vb8, en8, hs8, vs8;
  logic [31:0] addr8, dout8;
  logic [3:0]  r8, g8, b8;
  logic        ack16, fs16, vb16, en16, hs16, vs16;
  logic [31:0] addr16, dout16;
  logic [3:0]  r16, g16, b16;

  gpu_scanout #(
    .H_VIS_AREA_PXL(8), .H_FRONT_PORCH_PXL(2), .H_SYNC_PULSE_PXL(2), .H_BACK_PORCH_PXL(2),
    .V_VIS_AREA_PXL(4), .V_FRONT_PORCH_PXL(1), .V_SYNC_PULSE_PXL(1), .V_BACK_PORCH_PXL(1),
    .H_NUM_BITS(4), .V_NUM_BITS(3), .SCALE_SHIFT(1), .PIXEL_BITS(8), .CHANNEL_BITS(2),
    .READ_LATENCY(1), .HS_POL(1'b1), .VS_POL(1'b1), .FB_BASE_RESET(32'h0)
  ) dut (
    .vga_clk(clk), .reset(reset), .fb_base_next(fb_base_next), .flip_req(flip_req),
    .flip_ack(ack8), .frame_start(fs8), .vblank(vb8), .buffer_addr(addr8),
    .buffer_en(en8), .buffer_dout(dout8), .VGA_R(r8), .VGA_G(g8), .VGA_B(b8),
    .VGA_HS(hs8), .VGA_VS(vs8)
  );

  gpu_scanout #(
    .H_VIS_AREA_PXL(8), .H_FRONT_PORCH_PXL(2), .H_SYNC_PULSE_PXL(2), .H_BACK_PORCH_PXL(2),
    .V_VIS_AREA_PXL(4), .V_FRONT_PORCH_PXL(1), .V_SYNC_PULSE_PXL(1), .V_BACK_PORCH_PXL(1),
    .H_NUM_BITS(4), .V_NUM_BITS(3), .SCALE_SHIFT(0), .PIXEL_BITS(16), .CHANNEL_BITS(2),
    .READ_LATENCY(1), .HS_POL(1'b1), .VS_POL(1'b1), .FB_BASE_RESET(32'h0)
  ) dut16 (
    .vga_clk(clk), .reset(reset), .fb_base_next(32'h0), .flip_req(1'b0),
    .flip_ack(ack16), .frame_start(fs16), .vblank(vb16), .buffer_addr(addr16),
    .buffer_en(en16), .buffer_dout(dout16), .VGA_R(r16), .VGA_G(g16), .VGA_B(b16),
    .VGA_HS(hs16), .VGA_VS(vs16)
  );

  // Frame buffer where byte k holds value k (mod 256), one-cycle read latency
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    logic [7:0] b;
    b = a[7:0];
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  always @(posedge clk) begin
    dout8  <= ovr ? 32'h2727_2727 : mem_word(addr8);
    dout16 <= mem_word(addr16);
  end

  int checks = 0;
  int failures = 0;
  int k = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    k++;
  endtask

  typedef struct {
    int          h;
    int          v;
    logic        chk_addr;
    logic [31:0] addr;
    logic        en;
    logic [11:0] rgb;
    logic        hs;
    logic        vs;
  } vec_t;

  localparam int NV = 11;
  localparam int FRAME = 98;
  vec_t vecs [NV];

  int fs_err, vb_err, en_err, hs_err, vs_err, blank_err, ack_err, early_err, extra_ack;
  int h1, v1, h3, v3, ack_k;
  logic got_ack;

  initial begin
    vecs[0]  = '{0, 0, 1'b1, 32'h0, 1'b1, 12'h000, 1'b0, 1'b0};
    vecs[1]  = '{5, 2, 1'b1, 32'h4, 1'b1, 12'h05A, 1'b0, 1'b0};
    vecs[2]  = '{7, 3, 1'b1, 32'h4, 1'b1, 12'h05F, 1'b0, 1'b0};
    vecs[3]  = '{3, 1, 1'b1, 32'h0, 1'b1, 12'h005, 1'b0, 1'b0};
    vecs[4]  = '{6, 1, 1'b1, 32'h0, 1'b1, 12'h00F, 1'b0, 1'b0};
    vecs[5]  = '{2, 2, 1'b1, 32'h4, 1'b1, 12'h055, 1'b0, 1'b0};
    vecs[6]  = '{10, 0, 1'b0, 32'h0, 1'b0, 12'h000, 1'b1, 1'b0};
    vecs[7]  = '{11, 5, 1'b0, 32'h0, 1'b0, 12'h000, 1'b1, 1'b1};
    vecs[8]  = '{12, 5, 1'b0, 32'h0, 1'b0, 12'h000, 1'b0, 1'b1};
    vecs[9]  = '{9, 5, 1'b0, 32'h0, 1'b0, 12'h000, 1'b0, 1'b1};
    vecs[10] = '{3, 6, 1'b0, 32'h0, 1'b0, 12'h000, 1'b0, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_addr", addr8, 32'h0);
    chk("rst_en", {31'h0, en8}, 32'h0);
    chk("rst_rgb", {20'h0, r8, g8, b8}, 32'h0);
    chk("rst_sync", {30'h0, hs8, vs8}, 32'h0);
    chk("rst_fs_ack", {30'h0, fs8, ack8}, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    k = 0;

    // Three frames: table vectors plus per-cycle timing model
    fs_err = 0; vb_err = 0; en_err = 0; hs_err = 0; vs_err = 0; blank_err = 0; ack_err = 0;
    for (int n = 0; n < 3 * FRAME; n++) begin
      tick();
      h1 = (k - 1) % 14;
      v1 = ((k - 1) / 14) % 7;
      if (fs8 !== ((h1 == 0) && (v1 == 0))) fs_err++;
      if (vb8 !== (v1 >= 4)) vb_err++;
      if (en8 !== ((h1 < 8) && (v1 < 4))) en_err++;
      if (ack8 !== 1'b0) ack_err++;
      if (k >= 3) begin
        h3 = (k - 3) % 14;
        v3 = ((k - 3) / 14) % 7;
        if (hs8 !== ((h3 >= 10) && (h3 < 12))) hs_err++;
        if (vs8 !== (v3 == 5)) vs_err++;
        if (!((h3 < 8) && (v3 < 4)) && ({r8, g8, b8} !== 12'h0)) blank_err++;
      end else begin
        if (hs8 !== 1'b0) hs_err++;
        if (vs8 !== 1'b0) vs_err++;
        if ({r8, g8, b8} !== 12'h0) blank_err++;
      end
      for (int i = 0; i < NV; i++) begin
        if ((k - 1) == vecs[i].v * 14 + vecs[i].h) begin
          chk($sformatf("en_h%0d_v%0d", vecs[i].h, vecs[i].v), {31'h0, en8}, {31'h0, vecs[i].en});
          if (vecs[i].chk_addr)
            chk($sformatf("addr_h%0d_v%0d", vecs[i].h, vecs[i].v), addr8, vecs[i].addr);
        end
        if ((k - 3) == vecs[i].v * 14 + vecs[i].h) begin
          chk($sformatf("rgb_h%0d_v%0d", vecs[i].h, vecs[i].v), {20'h0, r8, g8, b8}, {20'h0, vecs[i].rgb});
          chk($sformatf("sync_h%0d_v%0d", vecs[i].h, vecs[i].v), {30'h0, hs8, vs8}, {30'h0, vecs[i].hs, vecs[i].vs});
        end
      end
      if (k == 4) begin
        chk("p16_addr", addr16, 32'h4);
        chk("p16_en", {31'h0, en16}, 32'h1);
      end
      if (k == 6) chk("p16_rgb", {20'h0, r16, g16, b16}, 32'h05A);
    end
    chk("frame_start_errs", fs_err, 0);
    chk("vblank_errs", vb_err, 0);
    chk("buffer_en_errs", en_err, 0);
    chk("hsync_errs", hs_err, 0);
    chk("vsync_errs", vs_err, 0);
    chk("blank_colour_errs", blank_err, 0);
    chk("idle_ack_errs", ack_err, 0);

    // Page flip requested mid-frame (counter h=6,v=1)
    for (int n = 0; n < 200 && (k % FRAME) != 20; n++) tick();
    fb_base_next = 32'h0000_0103;
    flip_req = 1'b1;
    early_err = 0;
    got_ack = 1'b0;
    for (int n = 0; n < 200 && !got_ack; n++) begin
      tick();
      if (en8 && (addr8 >= 32'h100)) early_err++;
      if (ack8) got_ack = 1'b1;
    end
    ack_k = k;
    flip_req = 1'b0;
    chk("flip_ack_seen", {31'h0, got_ack}, 32'h1);
    chk("flip_ack_pos", (ack_k - 1) % FRAME, 56);
    chk("flip_mid_frame_addr", early_err, 0);
    extra_ack = 0;
    for (int n = 0; n < 200 && ((k - 1) % FRAME) != 33; n++) begin
      tick();
      if (ack8) extra_ack++;
    end
    chk("flip_single_ack", extra_ack, 0);
    chk("flip_new_addr", addr8, 32'h104);
    chk("flip_new_en", {31'h0, en8}, 32'h1);

    // Asynchronous reset mid-line at h=5,v=1 with a non-zero pattern in the pipe
    for (int n = 0; n < 200 && (k % FRAME) != 19; n++) tick();
    ovr = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    chk("arst_addr_en", {addr8[30:0], en8}, 32'h0);
    chk("arst_rgb", {20'h0, r8, g8, b8}, 32'h0);
    chk("arst_sync_fs_ack", {28'h0, hs8, vs8, fs8, ack8}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    k = 0;
    tick();
    chk("post_rst_fs", {31'h0, fs8}, 32'h1);
    chk("post_rst_rgb1", {20'h0, r8, g8, b8}, 32'h0);
    tick();
    chk("post_rst_rgb2", {20'h0, r8, g8, b8}, 32'h0);
    tick();
    chk("colour_expand", {20'h0, r8, g8, b8}, 32'hA5F);
    chk("colour_sync", {30'h0, hs8, vs8}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
